lpddr_init_seq: RTL and testbench
=================================

Name: lpddr_init_seq

Overview:
- Responder side of the LPDDR reset/calibration handshake.
- The board support block drives `lpddr_reset` and waits for `lpddr_calib_done` before releasing the CPU from reset. This block is what answers it.
- After reset it runs the JEDEC-style SDRAM/LPDDR power-up sequence on the memory command bus: power-up wait, PRECHARGE ALL, N AUTO REFRESH, LOAD MODE. It then asserts `lpddr_calib_done`.
- Sits between the support block and the memory controller's command mux. The controller owns the bus once done is high.

Parameters:
- T_POWERUP, 10000: cycles with CKE low and deselect after reset release (200 us at 50 MHz).
- T_RP, 3: cycles from PRECHARGE to next command (>=2).
- T_RFC, 7: cycles from REFRESH to next command (>=2).
- T_MRD, 2: cycles from MRS/EMRS to next command or done (>=2).
- NUM_REFRESH, 2: AUTO REFRESH commands issued (1..15).
- MODE_REG, 13'h0031: address value driven during MRS.
- EMODE_REG, 13'h0000: address value driven during EMRS (optional feature only).
- CNT_W, 16: delay counter width; must hold max(T_*)-1.

Ports:
- sysclk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- lpddr_reset  in  1  synchronous active-high restart request from support block.
- lpddr_calib_done  out  1  init complete; memory usable.
- sdram_cke  out  1  clock enable.
- sdram_cs_n  out  1  chip select.
- sdram_ras_n  out  1  row strobe.
- sdram_cas_n  out  1  column strobe.
- sdram_we_n  out  1  write enable.
- sdram_ba  out  2  bank address.
- sdram_addr  out  13  address.

Behaviour:
- Reset (reset_n low, async):
  - state = S_HOLD.
  - cke=0, cs_n=ras_n=cas_n=we_n=1, ba=0, addr=0, calib_done=0.
- All outputs are registered.
- States: S_HOLD, S_PWR, S_PRE, S_WRP, S_REF, S_WRFC, S_MRS, S_WMRD, [S_EMRS, S_WEMRD], S_DONE.
- Cycle k is the k-th rising sysclk edge after reset_n deasserts with lpddr_reset low.
- S_HOLD → S_PWR when lpddr_reset=0. Counter is loaded with T_POWERUP-1; cke=0, deselect.
- S_PWR timing:
  - cke goes 1 after cycle T_POWERUP.
  - PRECHARGE ALL is visible after cycle T_POWERUP+1: cs/ras/we=0, cas=1, addr[10]=1, other addr bits 0, ba=0.
- Each command is driven for exactly one cycle. Every non-command cycle with cke=1 drives NOP (cs=0, ras/cas/we=1), with addr/ba held at 0.
- Command spacing: the next command appears exactly T_x cycles after the previous one.
  - PRE→REF: T_RP.
  - REF→REF: T_RFC.
  - last REF→MRS: T_RFC.
- REFRESH encoding: cs/ras/cas=0, we=1.
  - A 4-bit refresh counter decrements per REFRESH.
  - Leave S_WRFC for S_MRS when the count reaches 0; otherwise return to S_REF.
- MRS encoding: all four strobes 0, ba=2'b00, addr=MODE_REG.
- calib_done rises T_MRD cycles after MRS is visible.
  - It is sticky high in S_DONE, where outputs are NOP with cke=1.
- lpddr_reset=1 in any state:
  - Next edge goes to S_HOLD with reset output values; calib_done drops the same edge.
  - A sequence in progress is aborted; no partial command completes.
  - Restart begins from S_PWR when the request drops.
- lpddr_reset held high: remain in S_HOLD indefinitely.
- Counter reload happens on state entry. A zero-valued count is never used, because all T_x >= 2 (T_POWERUP >= 1).
- Simultaneous reset_n low and lpddr_reset: reset_n wins (async).

Optional Feature:
- LPDDR_EMR_EN defined:
  - After S_WMRD, issue EMRS (all strobes 0, ba=2'b10, addr=EMODE_REG) T_MRD cycles after MRS.
  - calib_done rises T_MRD cycles after EMRS.
- LPDDR_EMR_EN undefined:
  - S_EMRS/S_WEMRD are absent; S_WMRD → S_DONE.
  - EMODE_REG is ignored.

Decomposition:
- Shared package lpddr_pkg:
  - 4-bit command constants {cs_n,ras_n,cas_n,we_n}: CMD_NOP, CMD_DESEL, CMD_PRE, CMD_REF, CMD_MRS.
  - BA_MR / BA_EMR.
  - State encoding.
- One sub-module, lpddr_delay_timer:
  - Loadable CNT_W-bit down counter with a zero flag.
  - Clocked by sysclk, reset by reset_n.

Test Plan:
- Defaults overridden to T_POWERUP=8, T_RP=3, T_RFC=7, T_MRD=2, NUM_REFRESH=2; release reset_n → cke=1 after cycle 8, PRE after 9 (addr=13'h0400), REF after 12 and 19, MRS after 26 (addr=MODE_REG), calib_done=1 after 28 and stays high.
- Same bench with LPDDR_EMR_EN, EMODE_REG=13'h0020 → EMRS after 28 (ba=2'b10, addr=13'h0020), calib_done after 30.
- Pulse lpddr_reset for 1 cycle at cycle 15 (between refreshes) → next edge cke=0, deselect, no further REF. Sequence restarts and PRE appears 9 cycles after lpddr_reset falls.
- Assert reset_n low asynchronously mid-cycle in S_DONE → outputs and calib_done go to reset values without waiting for a clock edge. Full sequence repeats on release.
- NUM_REFRESH=1, then 15 → exactly 1, then 15 REFRESH commands counted on the bus, spaced 7 cycles apart.
- Hold lpddr_reset=1 for 100 cycles after reset release → cke=0, cs_n=1, calib_done=0 throughout. Sequence starts only after release.

Source files
------------

// File: rtl/lpddr_pkg.sv
// lpddr_pkg: shared definitions for the LPDDR power-up / calibration responder.
//   - SDRAM command encodings as {cs_n, ras_n, cas_n, we_n}
//   - bank-address selectors for the mode and extended mode registers
//   - sequencer state encoding and the registered command-bus struct
// Optional feature macro: LPDDR_EMR_EN adds the EMRS states.
package lpddr_pkg;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam logic [1:0] BA_MR  = 2'b00;
  localparam logic [1:0] BA_EMR = 2'b10;

  // A10 high during PRECHARGE selects all banks.
  localparam logic [12:0] ADDR_PALL = 13'h0400;

  typedef enum logic [3:0] {
    S_HOLD  = 4'd0,
    S_PWR   = 4'd1,
    S_PRE   = 4'd2,
    S_WRP   = 4'd3,
    S_REF   = 4'd4,
    S_WRFC  = 4'd5,
    S_MRS   = 4'd6,
    S_WMRD  = 4'd7,
`ifdef LPDDR_EMR_EN
    S_EMRS  = 4'd8,
    S_WEMRD = 4'd9,
`endif
    S_DONE  = 4'd10
  } state_e;

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        done;
  } bus_t;

  localparam bus_t BUS_RST = '{cke: 1'b0, cmd: CMD_DESEL, ba: 2'b00,
                               addr: 13'h0000, done: 1'b0};

endpackage

// File: rtl/lpddr_delay_timer.sv
// lpddr_delay_timer: loadable down counter that saturates at zero.
// Ports:
//   sysclk, reset_n  clock / async active-low reset
//   load_i           load load_val_i this cycle (takes priority over count)
//   load_val_i       reload value
//   zero_o           current count is zero
//   zero_nxt_o       count will be zero after the coming edge
module lpddr_delay_timer #(
  parameter int CNT_W = 16
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o,
  output logic             zero_nxt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o     = (cnt_q == '0);
  // Lets the owner register outputs that depend on the count one cycle early.
  assign zero_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/lpddr_init_seq.sv
// lpddr_init_seq: responder to the board support block's LPDDR reset /
// calibration handshake. Runs power-up wait, PRECHARGE ALL, NUM_REFRESH
// AUTO REFRESHes and LOAD MODE on the SDRAM command bus, then raises
// lpddr_calib_done and parks the bus in NOP for the memory controller.
// Optional feature macro: LPDDR_EMR_EN -- also issues EMRS (ba=2'b10,
// addr=EMODE_REG) T_MRD after MRS; done follows T_MRD after EMRS.
// Ports:
//   sysclk            clock
//   reset_n           async active-low reset
//   lpddr_reset       sync active-high restart request (holds in S_HOLD)
//   lpddr_calib_done  init complete
//   sdram_cke/cs_n/ras_n/cas_n/we_n/ba/addr  registered command bus
module lpddr_init_seq
  import lpddr_pkg::*;
#(
  parameter int          T_POWERUP   = 10000,
  parameter int          T_RP        = 3,
  parameter int          T_RFC       = 7,
  parameter int          T_MRD       = 2,
  parameter int          NUM_REFRESH = 2,
  parameter logic [12:0] MODE_REG    = 13'h0031,
  parameter logic [12:0] EMODE_REG   = 13'h0000,
  parameter int          CNT_W       = 16
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        lpddr_reset,
  output logic        lpddr_calib_done,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr
);

  // Command states load T_x-1: the command cycle itself consumes one count,
  // so the wait state exits exactly T_x cycles after the command.
  localparam logic [CNT_W-1:0] LD_PWR = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] LD_MRD = CNT_W'(T_MRD - 1);
  localparam logic [3:0]       NREF   = 4'(NUM_REFRESH);

  state_e           state_q, state_d;
  logic [3:0]       ref_q, ref_d;
  bus_t             bus_q, bus_d;
  logic             tmr_load, tmr_zero, tmr_zero_nxt;
  logic [CNT_W-1:0] tmr_val;

  lpddr_delay_timer #(.CNT_W(CNT_W)) u_tmr (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero),
    .zero_nxt_o (tmr_zero_nxt)
  );

  // State register (also holds the refresh count and registered outputs).
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HOLD;
      ref_q   <= '0;
      bus_q   <= BUS_RST;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      bus_q   <= bus_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (lpddr_reset) begin
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_HOLD:  state_d = S_PWR;
        S_PWR:   if (tmr_zero) state_d = S_PRE;
        S_PRE:   state_d = S_WRP;
        S_WRP:   if (tmr_zero) state_d = S_REF;
        S_REF:   state_d = S_WRFC;
        S_WRFC:  if (tmr_zero) state_d = (ref_q == '0) ? S_MRS : S_REF;
        S_MRS:   state_d = S_WMRD;
`ifdef LPDDR_EMR_EN
        S_WMRD:  if (tmr_zero) state_d = S_EMRS;
        S_EMRS:  state_d = S_WEMRD;
        S_WEMRD: if (tmr_zero) state_d = S_DONE;
`else
        S_WMRD:  if (tmr_zero) state_d = S_DONE;
`endif
        S_DONE:  state_d = S_DONE;
        default: state_d = S_HOLD;
      endcase
    end
  end

  // Timer reload on entry to a timed state; refresh count armed at PRECHARGE
  // and decremented as each REFRESH leaves the bus.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_d != state_q) begin
      case (state_d)
        S_PWR:   begin tmr_load = 1'b1; tmr_val = LD_PWR; end
        S_PRE:   begin tmr_load = 1'b1; tmr_val = LD_RP;  end
        S_REF:   begin tmr_load = 1'b1; tmr_val = LD_RFC; end
        S_MRS:   begin tmr_load = 1'b1; tmr_val = LD_MRD; end
`ifdef LPDDR_EMR_EN
        S_EMRS:  begin tmr_load = 1'b1; tmr_val = LD_MRD; end
`endif
        default: ;
      endcase
    end
    ref_d = ref_q;
    if (state_d == S_PRE)      ref_d = NREF;
    else if (state_q == S_REF) ref_d = ref_q - 1'b1;
  end

  // Output logic, decoded from the next state so the bus is registered.
  always_comb begin
    bus_d      = BUS_RST;
    bus_d.cke  = 1'b1;
    bus_d.cmd  = CMD_NOP;
    case (state_d)
      S_HOLD: begin
        bus_d.cke = 1'b0;
        bus_d.cmd = CMD_DESEL;
      end
      // CKE comes up on the final power-up cycle, one cycle ahead of PRE.
      S_PWR: if (!tmr_zero_nxt) begin
        bus_d.cke = 1'b0;
        bus_d.cmd = CMD_DESEL;
      end
      S_PRE: begin
        bus_d.cmd  = CMD_PRE;
        bus_d.addr = ADDR_PALL;
      end
      S_REF: bus_d.cmd = CMD_REF;
      S_MRS: begin
        bus_d.cmd  = CMD_MRS;
        bus_d.ba   = BA_MR;
        bus_d.addr = MODE_REG;
      end
`ifdef LPDDR_EMR_EN
      S_EMRS: begin
        bus_d.cmd  = CMD_MRS;
        bus_d.ba   = BA_EMR;
        bus_d.addr = EMODE_REG;
      end
`endif
      S_DONE:  bus_d.done = 1'b1;
      default: ;
    endcase
  end

`ifndef LPDDR_EMR_EN
  logic unused_emode;
  assign unused_emode = ^EMODE_REG;
`endif

  assign sdram_cke        = bus_q.cke;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = bus_q.cmd;
  assign sdram_ba         = bus_q.ba;
  assign sdram_addr       = bus_q.addr;
  assign lpddr_calib_done = bus_q.done;

endmodule

// File: tb/tb_lpddr_init_seq.sv
// Scoreboard bench for lpddr_init_seq: each sequence start pushes the expected
// bus events (CKE rise, commands, done rise) with absolute cycle stamps; a
// negedge monitor pops and compares as the DUT produces them.
module tb_lpddr_init_seq;

  localparam int TP = 8, TRP = 3, TRFC = 7, TMRD = 2, NR = 2;
  localparam logic [12:0] MR = 13'h0031, EMR = 13'h0020;
  localparam logic [3:0] C_NOP = 4'b0111, C_DES = 4'b1111, C_PRE = 4'b0010,
                         C_REF = 4'b0001, C_MRS = 4'b0000;
  localparam logic [1:0] K_CKE = 2'd1, K_CMD = 2'd2, K_DONE = 2'd3;
  localparam logic [20:0] RST_PAT = {1'b0, 1'b0, 4'hF, 2'b00, 13'h0};

  logic sysclk = 1'b0, reset_n = 1'b0, lpddr_reset = 1'b0;
  logic done, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0] ba;
  logic [12:0] addr;
  logic [3:0] m_cmd;
  logic [20:0] outs;

  logic x_rst_n = 1'b0;
  logic [1:0] x_cke, x_cs, x_ras, x_cas, x_we, x_done;
  logic [1:0][1:0] x_ba;
  logic [1:0][12:0] x_addr;
  logic [1:0][3:0] x_cmd;
  int x_n[2], x_last[2];

  int cyc = 0, n_chk = 0, n_err = 0, base;
  logic [63:0] sb[$];
  logic prev_cke = 1'b0, prev_done = 1'b0;

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  assign m_cmd = {cs_n, ras_n, cas_n, we_n};
  assign outs  = {done, cke, m_cmd, ba, addr};

  lpddr_init_seq #(.T_POWERUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
                   .NUM_REFRESH(NR), .MODE_REG(MR), .EMODE_REG(EMR), .CNT_W(16)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .lpddr_reset(lpddr_reset),
    .lpddr_calib_done(done), .sdram_cke(cke), .sdram_cs_n(cs_n),
    .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .sdram_ba(ba), .sdram_addr(addr));

  lpddr_init_seq #(.T_POWERUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
                   .NUM_REFRESH(1), .MODE_REG(MR), .EMODE_REG(EMR), .CNT_W(16)) dut_r1 (
    .sysclk(sysclk), .reset_n(x_rst_n), .lpddr_reset(1'b0),
    .lpddr_calib_done(x_done[0]), .sdram_cke(x_cke[0]), .sdram_cs_n(x_cs[0]),
    .sdram_ras_n(x_ras[0]), .sdram_cas_n(x_cas[0]), .sdram_we_n(x_we[0]),
    .sdram_ba(x_ba[0]), .sdram_addr(x_addr[0]));

  lpddr_init_seq #(.T_POWERUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
                   .NUM_REFRESH(15), .MODE_REG(MR), .EMODE_REG(EMR), .CNT_W(16)) dut_r15 (
    .sysclk(sysclk), .reset_n(x_rst_n), .lpddr_reset(1'b0),
    .lpddr_calib_done(x_done[1]), .sdram_cke(x_cke[1]), .sdram_cs_n(x_cs[1]),
    .sdram_ras_n(x_ras[1]), .sdram_cas_n(x_cas[1]), .sdram_we_n(x_we[1]),
    .sdram_ba(x_ba[1]), .sdram_addr(x_addr[1]));

  for (genvar g = 0; g < 2; g++) begin : g_xcmd
    assign x_cmd[g] = {x_cs[g], x_ras[g], x_cas[g], x_we[g]};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ev(input int c, input logic [1:0] k, input logic [3:0] cmd,
                                     input logic [1:0] b, input logic [12:0] a);
    return {11'h0, c[31:0], k, cmd, b, a};
  endfunction

  task automatic sb_pop(input string tag, input logic [63:0] got);
    if (sb.size() == 0) chk({tag, "_unexp"}, got, '1);
    else                chk(tag, got, sb.pop_front());
  endtask

  // Expected init sequence for a start whose cycle 1 is edge b+1.
  task automatic push_seq(input int b);
    int c;
    c = b + TP;            sb.push_back(ev(c, K_CKE, C_NOP, 2'b00, 13'h0));
    c = c + 1;             sb.push_back(ev(c, K_CMD, C_PRE, 2'b00, 13'h0400));
    c = c + TRP;
    for (int i = 0; i < NR; i++) begin
      sb.push_back(ev(c, K_CMD, C_REF, 2'b00, 13'h0));
      c = c + TRFC;
    end
    sb.push_back(ev(c, K_CMD, C_MRS, 2'b00, MR));
    c = c + TMRD;
`ifdef LPDDR_EMR_EN
    sb.push_back(ev(c, K_CMD, C_MRS, 2'b10, EMR));
    c = c + TMRD;
`endif
    sb.push_back(ev(c, K_DONE, C_NOP, 2'b00, 13'h0));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge sysclk);
    @(negedge sysclk);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Main monitor.
  always @(negedge sysclk) begin
    if (reset_n) begin
      if (cke && !prev_cke) sb_pop("cke_rise", ev(cyc, K_CKE, C_NOP, 2'b00, 13'h0));
      if (cke && m_cmd != C_NOP && m_cmd != C_DES)
        sb_pop("cmd", ev(cyc, K_CMD, m_cmd, ba, addr));
      else
        chk("idle_addr", 64'({ba, addr}), 64'd0);
      if (!cke) chk("desel_cke0", 64'(m_cmd), 64'(C_DES));
      if (done && !prev_done) sb_pop("done_rise", ev(cyc, K_DONE, C_NOP, 2'b00, 13'h0));
    end
    prev_cke  <= cke;
    prev_done <= done;
  end

  // Refresh count / spacing monitor for the NUM_REFRESH=1 and =15 instances.
  always @(negedge sysclk) begin
    for (int i = 0; i < 2; i++) begin
      if (x_rst_n && x_cke[i] && x_cmd[i] == C_REF) begin
        if (x_n[i] != 0) chk("ref_gap", 64'(cyc - x_last[i]), 64'(TRFC));
        x_n[i]    <= x_n[i] + 1;
        x_last[i] <= cyc;
      end
    end
  end

  initial begin
    x_n[0] = 0; x_n[1] = 0; x_last[0] = 0; x_last[1] = 0;
    repeat (3) @(negedge sysclk);
    chk("reset_vals", 64'(outs), 64'(RST_PAT));

    // Plain power-up sequence, then done must stay high.
    #1 reset_n = 1'b1; base = cyc; push_seq(base);
    drain("seq1_drain");
    repeat (5) begin
      @(negedge sysclk);
      chk("sticky", 64'({done, cke, m_cmd}), 64'({1'b1, 1'b1, C_NOP}));
    end

    // Abort between refreshes with a one-cycle lpddr_reset pulse.
    #1 reset_n = 1'b0;
    @(negedge sysclk); #1 reset_n = 1'b1; base = cyc; push_seq(base);
    while (cyc < base + 15) @(negedge sysclk);
    #1 lpddr_reset = 1'b1; sb.delete();
    @(negedge sysclk);
    chk("abort_vals", 64'(outs), 64'(RST_PAT));
    #1 lpddr_reset = 1'b0; base = cyc; push_seq(base);
    drain("restart_drain");

    // Async reset mid-cycle while in S_DONE.
    @(posedge sysclk); #3 reset_n = 1'b0;
    #1 chk("async_rst", 64'(outs), 64'(RST_PAT));
    @(negedge sysclk); #1 reset_n = 1'b1; base = cyc; push_seq(base);
    drain("async_drain");

    // lpddr_reset held high across reset release for 100 cycles.
    @(negedge sysclk); #1 reset_n = 1'b0; lpddr_reset = 1'b1;
    @(negedge sysclk); #1 reset_n = 1'b1;
    repeat (100) begin
      @(negedge sysclk);
      chk("hold", 64'({cke, cs_n, done}), 64'(3'b010));
    end
    #1 lpddr_reset = 1'b0; base = cyc; push_seq(base);
    drain("hold_drain");

    // Refresh-count variants.
    @(negedge sysclk); #1 x_rst_n = 1'b1;
    repeat (160) @(negedge sysclk);
    chk("r1_count",  64'(x_n[0]), 64'd1);
    chk("r15_count", 64'(x_n[1]), 64'd15);
    chk("x_done",    64'(x_done), 64'(2'b11));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
